// File: rtl/div_rem_pkg.sv
// rtl/div_rem_pkg.sv - shared encodings, state type and constants for the RV32M divide/remainder unit.
package div_rem_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    localparam logic [1:0] ORD_DIV  = 2'b00;
    localparam logic [1:0] ORD_DIVU = 2'b01;
    localparam logic [1:0] ORD_REM  = 2'b10;
    localparam logic [1:0] ORD_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_rem_unit_div_step.sv
// rtl/div_rem_unit_div_step.sv - one combinational restoring-division step.
module div_step
    import div_rem_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            quo_bit
);

    logic [XLEN:0] shifted;

    // A set top bit means the true shifted value exceeds 2^XLEN, so it always
    // covers the divisor and the modulo subtraction is still exact.
    always_comb begin
        shifted = {rem_in[XLEN-1:0], dividend_bit};
        quo_bit = rem_in[XLEN] | (shifted >= {1'b0, divisor});
        rem_out = quo_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/div_rem_unit.sv
// rtl/div_rem_unit.sv - multi-cycle RV32M DIV/DIVU/REM/REMU responder with cached quotient and remainder.
module div_rem_unit
    import div_rem_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] acc_in_A,
    input  logic [31:0] acc_in_B,
    input  logic [1:0]  div_rem_order,
    input  logic        div_rem_order_active,
    output logic        div_rem_ready,
    output logic [31:0] div_rem_result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;

    state_t            state;
    logic [XLEN-1:0]   lat_a;
    logic [XLEN-1:0]   lat_b;
    logic              lat_uns;
    logic [XLEN:0]     rem_w;
    logic [XLEN-1:0]   quo_w;
    logic              neg_q;
    logic              neg_r;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   q_fin;
    logic [XLEN-1:0]   r_fin;

    logic              match;
    logic              load;
    logic              req_signed;
    logic              b_zero;
    logic              ovf;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   divisor_abs;
    logic [XLEN-1:0]   quo_next;
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [XLEN:0]     rem_chain [0:BITS_PER_CYCLE];

    always_comb begin
        match = (acc_in_A == lat_a) && (acc_in_B == lat_b) &&
                (div_rem_order[0] == lat_uns);
        load  = div_rem_order_active &&
                ((state == IDLE) || ((state == DONE) && !match));

        req_signed = ~div_rem_order[0];
        b_zero     = (acc_in_B == '0);
        ovf        = req_signed && (acc_in_A == INT_MIN) && (acc_in_B == '1);
        abs_a      = req_signed ? abs32(acc_in_A) : acc_in_A;

        divisor_abs = lat_uns ? lat_b : abs32(lat_b);
    end

    // Dividend bits are consumed MSB-first from quo_w while quotient bits
    // enter at the bottom, so after N iterations quo_w holds the quotient.
    assign rem_chain[0] = rem_w;
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_step u_step (
            .rem_in       (rem_chain[g]),
            .dividend_bit (quo_w[XLEN-1-g]),
            .divisor      (divisor_abs),
            .rem_out      (rem_chain[g+1]),
            .quo_bit      (q_bits[BITS_PER_CYCLE-1-g])
        );
    end

    assign quo_next = (quo_w << BITS_PER_CYCLE) |
                      {{(XLEN-BITS_PER_CYCLE){1'b0}}, q_bits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat_a   <= '0;
            lat_b   <= '0;
            lat_uns <= 1'b0;
            rem_w   <= '0;
            quo_w   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            cnt     <= '0;
            q_fin   <= '0;
            r_fin   <= '0;
        end else if (load) begin
            lat_a   <= acc_in_A;
            lat_b   <= acc_in_B;
            lat_uns <= div_rem_order[0];
            neg_q   <= req_signed & (acc_in_A[XLEN-1] ^ acc_in_B[XLEN-1]) & ~b_zero;
            neg_r   <= req_signed & acc_in_A[XLEN-1];
            rem_w   <= '0;
            quo_w   <= abs_a;
            cnt     <= '0;
            if (b_zero) begin
                q_fin <= '1;
                r_fin <= acc_in_A;
                state <= DONE;
            end else if (ovf) begin
                q_fin <= INT_MIN;
                r_fin <= '0;
                state <= DONE;
            end else begin
                state <= BUSY;
            end
        end else begin
            case (state)
                BUSY: begin
                    // A flush or a changed request abandons the division.
                    if (!div_rem_order_active || !match) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(N)) begin
                        q_fin <= neg_q ? -quo_w : quo_w;
                        r_fin <= neg_r ? -rem_w[XLEN-1:0] : rem_w[XLEN-1:0];
                        state <= DONE;
                    end else begin
                        rem_w <= rem_chain[BITS_PER_CYCLE];
                        quo_w <= quo_next;
                        cnt   <= cnt + 1'b1;
                    end
                end
                IDLE, DONE: state <= state;
                default:    state <= IDLE;
            endcase
        end
    end

    always_comb begin
        div_rem_ready  = (state == DONE) && div_rem_order_active && match;
        div_rem_result = '0;
        if (div_rem_ready) begin
            div_rem_result = div_rem_order[1] ? r_fin : q_fin;
        end
    end

endmodule

// File: tb/tb_div_rem_unit.sv
// tb/tb_div_rem_unit.sv - directed and randomized checks of div_rem_unit at 1 and 4 bits per cycle.
module tb_div_rem_unit;
    import div_rem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a1, b1, a4, b4;
    logic [1:0]  o1, o4;
    logic        act1, act4;
    logic        rdy1, rdy4;
    logic [31:0] res1, res4;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    div_rem_unit #(.BITS_PER_CYCLE(1)) dut1 (
        .clk                  (clk),
        .reset                (reset),
        .acc_in_A             (a1),
        .acc_in_B             (b1),
        .div_rem_order        (o1),
        .div_rem_order_active (act1),
        .div_rem_ready        (rdy1),
        .div_rem_result       (res1)
    );

    div_rem_unit #(.BITS_PER_CYCLE(4)) dut4 (
        .clk                  (clk),
        .reset                (reset),
        .acc_in_A             (a4),
        .acc_in_B             (b4),
        .div_rem_order        (o4),
        .div_rem_order_active (act4),
        .div_rem_ready        (rdy4),
        .div_rem_result       (res4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // RISC-V M semantics straight from the ISA rules.
    function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] ord);
        logic is_rem;
        logic uns;
        is_rem = ord[1];
        uns    = ord[0];
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (uns) return is_rem ? (a % b) : (a / b);
        return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit sel, output int lat, output logic [31:0] res);
        lat = 0;
        #1;
        while (!(sel ? rdy4 : rdy1) && lat < 200) begin
            @(posedge clk);
            #2;
            lat++;
        end
        res = sel ? res4 : res1;
    endtask

    task automatic req1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        a1 = a; b1 = b; o1 = o; act1 = 1'b1;
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] res;
        logic [31:0] ra, rb, la, lb;
        logic [1:0]  ro;
        logic        lu, last_valid;
        int          exp_lat;
        int          sel;

        reset = 1'b1;
        a4 = '0; b4 = '0; o4 = ORD_DIV; act4 = 1'b0;
        req1(32'd100, 32'd7, ORD_DIV);
        #12;
        check("reset_ready", {31'b0, rdy1}, 32'd0);
        check("reset_result", res1, 32'd0);
        act1 = 1'b0;
        step();
        reset = 1'b0;
        step();

        // DIV 100/7 then REM from the cache
        req1(32'd100, 32'd7, ORD_DIV);
        wait_ready(0, lat, res);
        check("div100_7_lat", 32'(lat), 32'd34);
        check("div100_7", res, 32'd14);
        step(); o1 = ORD_REM; #1;
        check("rem100_7_ready", {31'b0, rdy1}, 32'd1);
        check("rem100_7", res1, 32'd2);
        step(); #1;
        check("rem100_7_hold", res1, 32'd2);
        step(); act1 = 1'b0; #1;
        check("bubble_no_ready", {31'b0, rdy1}, 32'd0);
        check("bubble_result", res1, 32'd0);
        step(); act1 = 1'b1; o1 = ORD_DIV; #1;
        check("cache_after_bubble_ready", {31'b0, rdy1}, 32'd1);
        check("cache_after_bubble", res1, 32'd14);

        // Signed -7/2, its REM, then DIVU re-divides
        step(); req1(32'hFFFF_FFF9, 32'd2, ORD_DIV);
        wait_ready(0, lat, res);
        check("divm7_2_lat", 32'(lat), 32'd34);
        check("divm7_2", res, 32'hFFFF_FFFD);
        step(); o1 = ORD_REM; #1;
        check("remm7_2_ready", {31'b0, rdy1}, 32'd1);
        check("remm7_2", res1, 32'hFFFF_FFFF);
        step(); o1 = ORD_DIVU;
        wait_ready(0, lat, res);
        check("divum7_2_lat", 32'(lat), 32'd34);
        check("divum7_2", res, 32'h7FFF_FFFC);

        // Divide by zero and signed overflow
        step(); req1(32'd5, 32'd0, ORD_DIVU);
        wait_ready(0, lat, res);
        check("divu5_0_lat", 32'(lat), 32'd1);
        check("divu5_0", res, 32'hFFFF_FFFF);
        step(); o1 = ORD_REMU; #1;
        check("remu5_0_ready", {31'b0, rdy1}, 32'd1);
        check("remu5_0", res1, 32'd5);
        step(); req1(INT_MIN, 32'hFFFF_FFFF, ORD_DIV);
        wait_ready(0, lat, res);
        check("ovf_div_lat", 32'(lat), 32'd1);
        check("ovf_div", res, 32'h8000_0000);
        step(); o1 = ORD_REM; #1;
        check("ovf_rem_ready", {31'b0, rdy1}, 32'd1);
        check("ovf_rem", res1, 32'd0);

        // Flush mid-division, then a fresh request
        step(); req1(32'd1000, 32'd13, ORD_DIV);
        seen = 0;
        #1;
        if (rdy1) seen++;
        repeat (10) begin
            step(); #1;
            if (rdy1) seen++;
        end
        step(); act1 = 1'b0; #1;
        if (rdy1) seen++;
        step(); req1(32'd9, 32'd3, ORD_DIV);
        wait_ready(0, lat, res);
        check("abort_no_ready", 32'(seen), 32'd0);
        check("div9_3_lat", 32'(lat), 32'd34);
        check("div9_3", res, 32'd3);

        // Reset in the middle of a division
        step(); req1(32'd77, 32'd5, ORD_DIV);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midreset_ready", {31'b0, rdy1}, 32'd0);
        check("midreset_result", res1, 32'd0);
        step();
        reset = 1'b0;
        wait_ready(0, lat, res);
        check("after_reset_lat", 32'(lat), 32'd34);
        check("after_reset_div", res, 32'd15);
        step(); act1 = 1'b0;

        // Randomized regression at 4 bits per cycle
        last_valid = 1'b0;
        la = '0; lb = '0; lu = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            ro  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) begin ra = INT_MIN; rb = 32'hFFFF_FFFF; ro[0] = 1'b0; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 100));
            if (last_valid && ra == la && rb == lb && ro[0] == lu)
                exp_lat = 0;
            else if (rb == 0 || (!ro[0] && ra == INT_MIN && rb == 32'hFFFF_FFFF))
                exp_lat = 1;
            else
                exp_lat = 10;
            step();
            a4 = ra; b4 = rb; o4 = ro; act4 = 1'b1;
            wait_ready(1, lat, res);
            check($sformatf("reg%0d_lat", i), 32'(lat), 32'(exp_lat));
            check($sformatf("reg%0d_res", i), res, ref_model(ra, rb, ro));
            step(); o4 = ro ^ 2'b10; #1;
            check($sformatf("reg%0d_pair_ready", i), {31'b0, rdy4}, 32'd1);
            check($sformatf("reg%0d_pair_res", i), res4, ref_model(ra, rb, ro ^ 2'b10));
            last_valid = 1'b1;
            la = ra; lb = rb; lu = ro[0];
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
